bram_arbiter: RTL and testbench



---
 rtl/bram_arbiter_pkg.sv | 18 +
 rtl/bram_arbiter_if.sv | 23 ++
 rtl/bram_arbiter_rr_pick.sv | 24 ++
 rtl/bram_arbiter.sv | 138 +++++++++++++
 tb/tb_bram_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_arbiter_pkg.sv
// Shared types and constants for the BRAM arbiter slice.
package atk16_bram_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_VID = 1'b1
  } port_id_t;

endpackage

// File: rtl/bram_arbiter_if.sv
// Level-enable / one-cycle-done BRAM handshake. The side issuing the
// request uses master; the side serving it uses slave.
interface bram_arbiter_if;
  import atk16_bram_pkg::*;

  logic              read_en;
  logic              write_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              done;

  modport master (
    output read_en, write_en, addr, data_in,
    input  data_out, done
  );

  modport slave (
    input  read_en, write_en, addr, data_in,
    output data_out, done
  );

endinterface

// File: rtl/bram_arbiter_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// port that did not win last time.
module bram_rr_pick
  import atk16_bram_pkg::*;
(
  input  logic     req_cpu,
  input  logic     req_vid,
  input  port_id_t last_grant,
  output logic     grant_valid,
  output port_id_t grant_id
);

  // Grant decision from the two request bits and the previous winner.
  always_comb begin
    grant_valid = req_cpu | req_vid;
    grant_id    = PORT_CPU;
    if (req_cpu && req_vid) begin
      grant_id = (last_grant == PORT_CPU) ? PORT_VID : PORT_CPU;
    end else if (req_vid) begin
      grant_id = PORT_VID;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port BRAM controller between the CPU and video fetch
// ports, with round-robin fairness and a completion timeout.
module bram_arbiter
  import atk16_bram_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  bram_arbiter_if.slave  cpu,
  bram_arbiter_if.slave  vid,
  bram_arbiter_if.master m,
  output logic           err
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  arb_state_t        state_q, state_d;
  port_id_t          last_grant_q, owner_q, grant_id;
  logic              grant_valid;
  logic [7:0]        cnt_q;
  logic              op_end, timed_out;
  logic              m_rd_q, m_wr_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_data_q;
  logic [DATA_W-1:0] cpu_dout_q, vid_dout_q;
  logic              cpu_done_q, vid_done_q, err_q;
  logic              sel_rd, sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  bram_rr_pick u_pick (
    .req_cpu     (cpu.read_en | cpu.write_en),
    .req_vid     (vid.read_en | vid.write_en),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Route the winning port's request fields toward the controller registers.
  always_comb begin
    sel_rd   = cpu.read_en;
    sel_wr   = cpu.write_en;
    sel_addr = cpu.addr;
    sel_data = cpu.data_in;
    if (grant_id == PORT_VID) begin
      sel_rd   = vid.read_en;
      sel_wr   = vid.write_en;
      sel_addr = vid.addr;
      sel_data = vid.data_in;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB;
    else        state_q <= state_d;
  end

  // Next state; a completion from the controller takes priority over timeout.
  always_comb begin
    state_d   = state_q;
    op_end    = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      ARB:  if (grant_valid) state_d = BUSY;
      BUSY: begin
        if (m.done) begin
          op_end  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == TMO) begin
          op_end    = 1'b1;
          timed_out = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Controller-side registers, per-port results, timeout counter and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_VID;
      owner_q      <= PORT_CPU;
      cnt_q        <= '0;
      m_rd_q       <= 1'b0;
      m_wr_q       <= 1'b0;
      m_addr_q     <= '0;
      m_data_q     <= '0;
      cpu_dout_q   <= '0;
      vid_dout_q   <= '0;
      cpu_done_q   <= 1'b0;
      vid_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cpu_done_q <= 1'b0;
      vid_done_q <= 1'b0;
      if (state_q == ARB && grant_valid) begin
        m_addr_q     <= sel_addr;
        m_data_q     <= sel_data;
        m_rd_q       <= sel_rd;
        m_wr_q       <= sel_wr & ~sel_rd;
        owner_q      <= grant_id;
        last_grant_q <= grant_id;
        cnt_q        <= '0;
      end else if (state_q == BUSY) begin
        if (op_end) begin
          m_rd_q <= 1'b0;
          m_wr_q <= 1'b0;
          // m_rd_q still reflects the finishing op here, so it qualifies capture.
          if (owner_q == PORT_CPU) begin
            cpu_done_q <= 1'b1;
            if (!timed_out && m_rd_q) cpu_dout_q <= m.data_out;
          end else begin
            vid_done_q <= 1'b1;
            if (!timed_out && m_rd_q) vid_dout_q <= m.data_out;
          end
          if (timed_out) err_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  assign m.read_en    = m_rd_q;
  assign m.write_en   = m_wr_q;
  assign m.addr       = m_addr_q;
  assign m.data_in    = m_data_q;
  assign cpu.data_out = cpu_dout_q;
  assign cpu.done     = cpu_done_q;
  assign vid.data_out = vid_dout_q;
  assign vid.done     = vid_done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: requester and controller stand-ins, a
// transaction-timeline reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_bram_arbiter;
  import atk16_bram_pkg::*;

  localparam int T = 15;

  logic clk = 1'b0;
  logic rst_n;
  logic err;
  always #5 clk = ~clk;

  bram_arbiter_if cpu_if();
  bram_arbiter_if vid_if();
  bram_arbiter_if m_if();

  bram_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cpu   (cpu_if),
    .vid   (vid_if),
    .m     (m_if),
    .err   (err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- requester stand-ins (index 0 = cpu, 1 = vid) ----------
  logic        rd [2]   = '{1'b0, 1'b0};
  logic        wr [2]   = '{1'b0, 1'b0};
  logic [15:0] ra [2]   = '{16'h0, 16'h0};
  logic [15:0] rdin [2] = '{16'h0, 16'h0};
  bit          busy [2], go [2], hold [2], hold_once [2];
  logic        g_rd [2], g_wr [2];
  logic [15:0] g_addr [2], g_din [2];
  int          done_cnt [2], done_cyc [2], raise_cyc [2];
  int          dlog_p [$];
  int          dlog_c [$];
  bit          rand_on = 1'b0;
  int          rate = 30;

  assign cpu_if.read_en  = rd[0];
  assign cpu_if.write_en = wr[0];
  assign cpu_if.addr     = ra[0];
  assign cpu_if.data_in  = rdin[0];
  assign vid_if.read_en  = rd[1];
  assign vid_if.write_en = wr[1];
  assign vid_if.addr     = ra[1];
  assign vid_if.data_in  = rdin[1];

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        busy[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (busy[p]) begin
          if ((p == 0) ? cpu_if.done : vid_if.done) begin
            done_cnt[p]++;
            done_cyc[p] = cyc;
            dlog_p.push_back(p);
            dlog_c.push_back(cyc);
            if (hold[p] || hold_once[p]) hold_once[p] = 1'b0;
            else begin
              busy[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
            end
          end
        end else if (go[p]) begin
          go[p] = 1'b0; busy[p] = 1'b1; raise_cyc[p] = cyc;
          rd[p] = g_rd[p]; wr[p] = g_wr[p]; ra[p] = g_addr[p]; rdin[p] = g_din[p];
        end else if (rand_on && $urandom_range(99) < rate) begin
          int k;
          k = $urandom_range(3);
          busy[p] = 1'b1; raise_cyc[p] = cyc;
          rd[p] = (k != 1); wr[p] = (k == 1 || k == 2);
          ra[p] = 16'($urandom_range(7)); rdin[p] = 16'($urandom);
        end
      end
    end
  end

  // ---------------- controller stand-in (done on 3rd enabled cycle) -------
  logic        ctl_done = 1'b0;
  logic [15:0] ctl_dout = 16'h0;
  bit          stuck = 1'b0, stray = 1'b0;
  int          en_cnt = 0;
  logic [15:0] ctl_mem [int];

  assign m_if.done     = ctl_done;
  assign m_if.data_out = ctl_dout;

  always @(posedge clk) begin
    #2;
    ctl_done = 1'b0;
    ctl_dout = 16'($urandom);
    if (stray) begin
      ctl_done = 1'b1;
      en_cnt   = 0;
    end else if (m_if.read_en || m_if.write_en) begin
      en_cnt++;
      if (en_cnt == 3 && !stuck) begin
        ctl_done = 1'b1;
        if (m_if.read_en)
          ctl_dout = ctl_mem.exists(int'(m_if.addr)) ? ctl_mem[int'(m_if.addr)] : 16'h0;
        else
          ctl_mem[int'(m_if.addr)] = m_if.data_in;
      end
    end else begin
      en_cnt = 0;
    end
  end

  // ---------------- reference model + per-cycle compare -------------------
  bit          mo_active = 1'b0, mo_tmo;
  int          mo_s, mo_L, mo_owner, next_sample = 0, last_grant = 1;
  logic        mo_rd, mo_wr;
  logic [15:0] mo_addr, mo_din;
  logic [15:0] e_maddr = 16'h0, e_mdin = 16'h0;
  logic [15:0] e_dout [2] = '{16'h0, 16'h0};
  logic        e_err = 1'b0;
  logic [15:0] ref_mem [int];
  int          mw_cnt = 0, mr_cnt = 0;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    else n_pass++;
  endtask

  task automatic lit(string name, int act, int exp);
    n_checks++;
    if (act != exp) $display("FAIL %s got=%0d want=%0d", name, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    logic e_mrd, e_mwr, e_d0, e_d1;
    if (!rst_n) begin
      mo_active = 1'b0; next_sample = 0; last_grant = 1;
      e_maddr = 16'h0; e_mdin = 16'h0; e_dout[0] = 16'h0; e_dout[1] = 16'h0; e_err = 1'b0;
    end
    e_mrd = 1'b0; e_mwr = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
    if (mo_active) begin
      if (cyc == mo_s + 1) begin
        e_maddr = mo_addr; e_mdin = mo_din;
      end
      if (cyc >= mo_s + 1 && cyc < mo_s + mo_L) begin
        e_mrd = mo_rd; e_mwr = mo_wr;
      end
      if (cyc == mo_s + mo_L) begin
        if (mo_owner == 0) e_d0 = 1'b1; else e_d1 = 1'b1;
        if (mo_tmo) e_err = 1'b1;
        else if (mo_rd)
          e_dout[mo_owner] = ref_mem.exists(int'(mo_addr)) ? ref_mem[int'(mo_addr)] : 16'h0;
        else
          ref_mem[int'(mo_addr)] = mo_din;
        mo_active   = 1'b0;
        next_sample = cyc + 1;
      end
    end
    if (m_if.write_en === 1'b1) mw_cnt++;
    if (m_if.read_en === 1'b1) mr_cnt++;
    chk("m_read_en",    16'(m_if.read_en),  16'(e_mrd));
    chk("m_write_en",   16'(m_if.write_en), 16'(e_mwr));
    chk("m_addr",       m_if.addr,          e_maddr);
    chk("m_data_in",    m_if.data_in,       e_mdin);
    chk("cpu_done",     16'(cpu_if.done),   16'(e_d0));
    chk("vid_done",     16'(vid_if.done),   16'(e_d1));
    chk("cpu_data_out", cpu_if.data_out,    e_dout[0]);
    chk("vid_data_out", vid_if.data_out,    e_dout[1]);
    chk("err",          16'(err),           16'(e_err));
    if (rst_n && !mo_active && cyc >= next_sample) begin
      bit q0, q1;
      q0 = rd[0] | wr[0];
      q1 = rd[1] | wr[1];
      if (q0 || q1) begin
        mo_owner   = (q0 && q1) ? 1 - last_grant : (q0 ? 0 : 1);
        last_grant = mo_owner;
        mo_rd      = rd[mo_owner];
        mo_wr      = wr[mo_owner] & ~rd[mo_owner];
        mo_addr    = ra[mo_owner];
        mo_din     = rdin[mo_owner];
        mo_s       = cyc;
        mo_tmo     = stuck;
        mo_L       = stuck ? T + 2 : 4;
        mo_active  = 1'b1;
      end
    end
  end

  // ---------------- directed + random stimulus ----------------------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic issue(int p, logic r, logic w, logic [15:0] a, logic [15:0] d);
    g_rd[p] = r; g_wr[p] = w; g_addr[p] = a; g_din[p] = d; go[p] = 1'b1;
  endtask

  task automatic wait_done(int p, int prev, output int dc);
    int n;
    n = 0;
    while (done_cnt[p] == prev && n < 60) begin
      tick(); n++;
    end
    if (done_cnt[p] == prev) begin
      n_checks++;
      $display("FAIL wait_done port%0d no completion within bound", p);
      dc = -1;
    end else dc = done_cyc[p];
  endtask

  task automatic wait_log(int want);
    int n;
    n = 0;
    while (dlog_p.size() < want && n < 80) begin
      tick(); n++;
    end
    if (dlog_p.size() < want) begin
      n_checks++;
      $display("FAIL wait_log only %0d of %0d completions", dlog_p.size(), want);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy[0] || busy[1] || go[0] || go[1]) && n < 200) begin
      tick(); n++;
    end
    if (busy[0] || busy[1]) begin
      n_checks++;
      $display("FAIL wait_idle requesters still busy");
    end
    tick(); tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int dc, s0, mw0, mr0, base, dn0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // CPU write then read back.
    mw0 = mw_cnt;
    issue(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
    wait_done(0, done_cnt[0], dc);
    lit("wr_latency", dc - raise_cyc[0], 4);
    lit("wr_en_cycles", mw_cnt - mw0, 3);
    issue(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    wait_done(0, done_cnt[0], dc);
    lit("rd_data", int'(cpu_if.data_out), 16'hBEEF);
    lit("rd_latency", dc - raise_cyc[0], 4);

    // Tie right after reset, then continuous alternation.
    do_reset();
    base = dlog_p.size();
    hold[0] = 1'b1; hold[1] = 1'b1;
    s0 = cyc + 1;
    issue(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    issue(1, 1'b1, 1'b0, 16'h0010, 16'h0);
    wait_log(base + 4);
    hold[0] = 1'b0; hold[1] = 1'b0;
    if (dlog_p.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        lit("tie_order", dlog_p[base + i], i % 2);
        lit("tie_spacing", dlog_c[base + i] - s0, 4 + 5 * i);
      end
    end
    wait_idle();
    lit("tie_vid_data", int'(vid_if.data_out), 16'hBEEF);

    // Video read and write both set: read wins.
    mw0 = mw_cnt; mr0 = mr_cnt;
    issue(1, 1'b1, 1'b1, 16'h0010, 16'h1234);
    wait_done(1, done_cnt[1], dc);
    lit("rw_vid_data", int'(vid_if.data_out), 16'hBEEF);
    lit("rw_no_write", mw_cnt - mw0, 0);
    lit("rw_read_cycles", mr_cnt - mr0, 3);

    // Controller never completes: timeout.
    stuck = 1'b1;
    issue(0, 1'b1, 1'b0, 16'h0003, 16'h0);
    wait_done(0, done_cnt[0], dc);
    stuck = 1'b0;
    lit("tmo_latency", dc - raise_cyc[0], T + 2);
    lit("tmo_err", int'(err), 1);
    lit("tmo_data_kept", int'(cpu_if.data_out), 16'hBEEF);
    tick();
    issue(0, 1'b0, 1'b1, 16'h0020, 16'h5A5A);
    wait_done(0, done_cnt[0], dc);
    lit("post_tmo_latency", dc - raise_cyc[0], 4);
    lit("err_sticky", int'(err), 1);
    tick();

    // Reset during BUSY, then a stray controller done.
    issue(0, 1'b0, 1'b1, 16'h0030, 16'hCAFE);
    tick(); tick();
    lit("busy_before_rst", int'(m_if.write_en), 1);
    dn0 = done_cnt[0];
    rst_n = 1'b0;
    #1;
    lit("rst_m_wr", int'(m_if.write_en), 0);
    lit("rst_m_addr", int'(m_if.addr), 0);
    lit("rst_m_data", int'(m_if.data_in), 0);
    lit("rst_cpu_dout", int'(cpu_if.data_out), 0);
    lit("rst_err", int'(err), 0);
    tick(); tick();
    rst_n = 1'b1;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    repeat (8) tick();
    lit("rst_no_done", done_cnt[0] - dn0, 0);
    lit("rst_arb_idle", int'(m_if.read_en | m_if.write_en), 0);

    // Requester holds its enable one cycle too long.
    base = dlog_p.size();
    mw0 = mw_cnt;
    hold_once[0] = 1'b1;
    issue(0, 1'b0, 1'b1, 16'h0040, 16'h7777);
    tick();
    s0 = raise_cyc[0];
    wait_log(base + 2);
    if (dlog_p.size() >= base + 2) begin
      lit("hold_first", dlog_c[base] - s0, 4);
      lit("hold_second", dlog_c[base + 1] - s0, 9);
    end
    wait_idle();
    lit("hold_wr_cycles", mw_cnt - mw0, 6);

    // Randomized traffic on both ports.
    rand_on = 1'b1;
    repeat (600) tick();
    rand_on = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
